// File: rtl/ddc_iq_fifo.sv
// I/Q sample FIFO at the DDC output: packs each accepted pair into one word,
// presents the head first-word-fall-through, and tracks fill threshold and drops.
module ddc_iq_fifo #(
  parameter int osz = 16,
  parameter int aw  = 9,
  parameter int csz = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic [osz-1:0]   i_in,
  input  logic [osz-1:0]   q_in,
  input  logic             cap_ena,
  input  logic             flush,
  input  logic             rd,
  input  logic [aw:0]      irq_lvl,
  input  logic             ovf_clr,
  output logic [2*osz-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic [aw:0]      level,
  output logic             thr,
  output logic             ovf,
  output logic [csz-1:0]   ovf_cnt
);

  localparam int DEPTH = 2**aw;
  localparam logic [aw:0]    LVL_FULL = (aw+1)'(DEPTH);
  localparam logic [aw:0]    LVL_ONE  = (aw+1)'(1);
  localparam logic [aw-1:0]  PTR_ONE  = aw'(1);
  localparam logic [csz-1:0] CNT_ONE  = csz'(1);

  logic [2*osz-1:0] mem [DEPTH];
  logic [aw-1:0] wptr, rptr, wptr_next, rptr_next;
  logic [aw:0]   level_next;
  logic          wr, pop, wr_ok, drop;

  assign empty = (level == '0);
  assign full  = (level == LVL_FULL);
  assign rdata = mem[rptr];

  // A pop frees the head slot in the same cycle, so a write while full is kept.
  always_comb begin
    wr         = valid & cap_ena;
    pop        = rd & ~empty & ~flush;
    wr_ok      = wr & (~full | pop) & ~flush;
    drop       = wr & full & ~pop & ~flush;
    wptr_next  = wptr;
    rptr_next  = rptr;
    level_next = level;
    if (flush) begin
      wptr_next  = '0;
      rptr_next  = '0;
      level_next = '0;
    end else begin
      if (wr_ok) wptr_next = wptr + PTR_ONE;
      if (pop)   rptr_next = rptr + PTR_ONE;
      case ({wr_ok, pop})
        2'b10:   level_next = level + LVL_ONE;
        2'b01:   level_next = level - LVL_ONE;
        default: level_next = level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      thr   <= 1'b0;
    end else begin
      wptr  <= wptr_next;
      rptr  <= rptr_next;
      level <= level_next;
      thr   <= (level_next >= irq_lvl);
    end
  end

  // A drop coinciding with a clear survives as the first counted drop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf     <= 1'b0;
      ovf_cnt <= '0;
    end else if (ovf_clr) begin
      ovf     <= drop;
      ovf_cnt <= drop ? CNT_ONE : '0;
    end else if (drop) begin
      ovf <= 1'b1;
      if (ovf_cnt != '1) ovf_cnt <= ovf_cnt + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr] <= {i_in, q_in};
  end

endmodule

// File: doc/ddc_iq_fifo.md
Name: ddc_iq_fifo

Overview:
- Buffers the decimated quadrature baseband stream at the output of the DDC. Each valid I/Q pair is packed into one 32-bit word and held in a first-word-fall-through FIFO.
- The FIFO is drained by the LiteX CSR/DMA side at its own pace.
- Also provides a fill-level threshold flag and overflow accounting, so software can detect lost samples at the 19.5–156 kSPS output rates.

Parameters:
- osz, 16, width of each I and Q sample (packed word is 2*osz bits)
- aw, 9, FIFO address width; depth = 2**aw entries (512)
- csz, 16, overflow counter width

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- valid  input  1  one-cycle strobe: new I/Q pair present on i_in/q_in
- i_in  input  osz  signed in-phase sample
- q_in  input  osz  signed quadrature sample
- cap_ena  input  1  capture enable; when low, valid strobes are ignored and not counted
- flush  input  1  synchronous FIFO clear (one-cycle pulse)
- rd  input  1  pop strobe from the read side
- irq_lvl  input  aw+1  fill-level threshold
- ovf_clr  input  1  synchronous clear of the overflow counter and sticky flag
- rdata  output  2*osz  head entry, {i[osz-1:0], q[osz-1:0]}
- empty  output  1  FIFO holds 0 entries
- full  output  1  FIFO holds 2**aw entries
- level  output  aw+1  current entry count, 0..2**aw
- thr  output  1  level >= irq_lvl (registered)
- ovf  output  1  sticky: at least one sample was dropped since the last ovf_clr or reset
- ovf_cnt  output  csz  dropped-sample count, saturating

Behaviour:
- Reset (async, active-high): write/read pointers = 0, level = 0, empty = 1, full = 0, thr = 0 if irq_lvl != 0 (after first clock), ovf = 0, ovf_cnt = 0. rdata is don't-care while empty. Reset takes effect immediately regardless of any in-progress write or read.
- Write acceptance: wr = valid & cap_ena.
  - An accepted write stores {i_in, q_in} at wptr; wptr increments modulo 2**aw.
- Read acceptance: a pop occurs when rd & !empty.
  - rptr increments modulo 2**aw.
  - rd while empty is ignored: no pointer change, no error.
- FWFT: whenever empty = 0, rdata presents the oldest entry. rdata may be combinational from storage; LUT RAM is permitted.
- Latency: empty, level, full and thr update on the clock edge following the accepting cycle. A sample written in cycle N is visible on rdata with empty = 0 from cycle N+1.
- Level update:
  - write only: +1
  - pop only: -1
  - write and pop together: unchanged
- Full boundary:
  - write with full and no pop: the sample is dropped; ovf_cnt += 1 (saturating at 2**csz-1); ovf is set.
  - write with full and a pop in the same cycle: the write is accepted and level stays 2**aw; no overflow.
- Empty boundary: write and rd in the same cycle while empty: the write is accepted, the rd is ignored, and level becomes 1.
- Pointer wrap: pointers wrap silently. full/empty are derived from level, not from pointer compare.
- flush (highest priority below reset):
  - pointers and level go to 0; empty = 1 next cycle.
  - A write or pop in the same cycle is discarded and not counted as overflow.
  - ovf and ovf_cnt are unaffected.
- ovf_clr: clears ovf and ovf_cnt next cycle. If a drop coincides with ovf_clr, the result is ovf = 1, ovf_cnt = 1.
- thr is registered from the next-state level: thr = (level_next >= irq_lvl). irq_lvl = 0 forces thr = 1.
- Packing: i_in is placed in the upper half and q_in in the lower half, with no sign manipulation.

Test Plan:
- Basic order: reset, cap_ena = 1, write 4 pairs (i = 1..4, q = -1..-4), then pop 4 → rdata = 0x0001FFFF, 0x0002FFFE, 0x0003FFFD, 0x0004FFFC; level goes 4→0 and empty = 1 after the last pop.
- Overflow: aw = 9, write 515 pairs with no rd → full = 1, level = 512, ovf = 1, ovf_cnt = 3; the first pop returns pair #1 (pair #1 retained, pairs #513–515 dropped).
- Full with simultaneous read/write: fill to 512, then assert valid and rd together for 10 cycles → level stays 512, ovf_cnt = 0, and the popped data is the oldest 10 in order.
- Gating and empty read: cap_ena = 0 with 8 valid strobes → level = 0, ovf_cnt = 0; rd pulses while empty → level remains 0 and no pointer corruption (a subsequent write/read of 0x12345678 round-trips).
- Threshold and wrap: irq_lvl = 100; write 100 → thr rises the cycle after the 100th write; pop 1 → thr = 0. Stream 2000 pairs at 1 write/1 read per cycle → data ordering is intact across 3+ pointer wraps.
- Flush, clear, async reset: with level = 50, flush coincident with valid → level = 0 next cycle and ovf_cnt unchanged. ovf_clr coincident with a drop → ovf_cnt = 1. Assert reset mid-burst between clock edges → all outputs reach reset values immediately, without waiting for the next clk edge.
